param_alu_mdu: RTL
==================

# param_alu_mdu

Parametrised, registered successor to the single-cycle datapath ALU. It keeps the 16-operation FunSel set and the {Z, C, N, O} flag register, generalised to WIDTH bits. It adds a Start/Busy/Done handshake and an optional iterative multiply/divide unit (WIDTH cycles per operation). It sits between the register-file A/B buses and the result mux, and the control unit sequences it.

## Interface
- WIDTH, 32: datapath width; must be ≥ 8.
- Clock  in  1  sole clock; all state changes on posedge.
- Reset  in  1  synchronous, active-low; sampled on the Clock posedge.
- Start  in  1  request; sampled only when Busy = 0.
- FunSel  in  5  operation select.
- WF  in  1  write-flags enable; latched with Start.
- A, B  in  WIDTH  operands; latched with Start.
- ALUOut  out  WIDTH  registered result; holds its value until the next Done.
- FlagsOut  out  4  {Z, C, N, O}.
- Busy  out  1  high while a multi-cycle operation iterates.
- Done  out  1  one-cycle pulse; ALUOut and FlagsOut are valid in the same cycle.

## Operation

FunSel 0x00–0x0F are single-cycle operations:
- 0x00 A; 0x01 B; 0x02 ~A; 0x03 ~B.
- 0x04 A+B; 0x05 A+B+C; 0x06 A−B, computed as A+~B+1.
- 0x07 AND; 0x08 OR; 0x09 XOR; 0x0A NAND.
- 0x0B LSL; 0x0C LSR; 0x0D ASR; 0x0E CSL (C shifts into bit 0); 0x0F CSR (C shifts into the MSB).

FunSel 0x10–0x13 are multi-cycle, available only with the macro in ## Configuration:
- 0x10 MUL: low WIDTH bits, unsigned.
- 0x11 MULH: high WIDTH bits, unsigned.
- 0x12 DIV: unsigned quotient.
- 0x13 REM: unsigned remainder.

FunSel 0x14–0x1F are reserved: single-cycle, ALUOut = A, no flag write.

Flag rules (applied only if WF was latched high):
- Z = (result == 0) and N = result[WIDTH−1], for all non-reserved operations.
- C for ADD, ADC and SUB: carry-out of the WIDTH-bit add. SUB therefore gives C = 1 when there is no borrow.
- C for shifts: the bit shifted out.
- O for ADD and ADC: operand signs equal and result sign differs.
- O for SUB: operand signs differ and result sign equals B's sign.
- MUL and MULH: C = 1 if the high half is nonzero; O unchanged.
- DIV and REM: C unchanged; O = 1 only on divide-by-zero, otherwise O = 0.
- Flags not listed for an operation keep their value.
- ADC, CSL and CSR use the C value present at Start.

Divide-by-zero (B == 0):
- Completes as a single-cycle operation.
- DIV result is all-ones; REM result is A.

State machine: IDLE → RUN → FIN → IDLE.
- IDLE, Start & single-cycle/reserved op: compute, register the result and flags, pulse Done; stay in IDLE.
- IDLE, Start & multi-cycle op (nonzero divisor): latch operands, clear the accumulator, load the counter with WIDTH, go to RUN.
- RUN: one shift-add (MUL) or restoring-subtract (DIV) step per cycle; decrement the counter; go to FIN when it reaches 0 after the last step.
- FIN: write ALUOut and flags, pulse Done, return to IDLE.
- Start while Busy = 1 is ignored (no queueing).

## Timing
- Reset values: ALUOut = 0, FlagsOut = 4'b0000, Busy = 0, Done = 0, state = IDLE.
- Reset asserted mid-RUN aborts the operation: no Done pulse, and flags return to zero.
- Single-cycle latency: Start at edge t, result and Done visible after edge t+1.
- Multi-cycle latency: Busy is high for cycles t+1 … t+WIDTH; Done fires at t+WIDTH+1 with Busy = 0.
- A new Start is accepted in the Done cycle (back-to-back issue).
- A, B, FunSel and WF may change freely after the Start cycle.

## Configuration
- ALU_MDU_EN defined: MUL, MULH, DIV and REM are implemented as described above.
- ALU_MDU_EN undefined:
  - FunSel 0x10–0x13 behave as reserved (ALUOut = A, flags unchanged, Done at t+1).
  - The RUN and FIN logic is not synthesised, and Busy is tied to 0.

## Test plan
1. Flags on ADD (WIDTH=32): ADD 0xFFFFFFFF + 0x00000001, WF = 1 → Done at t+1, ALUOut = 0x00000000, FlagsOut = 4'b1100.
2. Overflow on SUB: SUB 0x80000000 − 0x00000001, WF = 1 → ALUOut = 0x7FFFFFFF, FlagsOut = 4'b0101. WF = 0 variant → FlagsOut unchanged.
3. MUL/MULH with ALU_MDU_EN: MUL 0x00010000 × 0x00010000 → Busy for 32 cycles, Done at t+33, ALUOut = 0, Z = 1, C = 1. MULH of the same operands → ALUOut = 0x00000001.
4. DIV/REM: DIV 100 / 7 → 14; REM 100 / 7 → 2. DIV 5 / 0 → ALUOut = 0xFFFFFFFF at t+1, O = 1.
5. Handshake and reset: Start pulsed during Busy is ignored and the result still matches the first operation. Reset driven low at t+10 of a MUL → Busy = 0, no Done, FlagsOut = 0 next cycle.
6. Macro off: without ALU_MDU_EN, FunSel 0x10 with A = 0x12345678 → ALUOut = 0x12345678, flags unchanged, Busy never high.

Source files
------------

// File: rtl/param_alu_mdu.sv
// Registered WIDTH-bit ALU with {Z,C,N,O} flags and a Start/Busy/Done handshake.
// Define ALU_MDU_EN to add the iterative unsigned MUL/MULH/DIV/REM unit (FunSel 0x10-0x13).
module param_alu_mdu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [4:0]       FunSel,
  input  logic             WF,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALUOut,
  output logic [3:0]       FlagsOut,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH-1:0] sc_res;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH:0]   sum;
  logic             cin;
  logic             c_v;
  logic             o_v;
  logic             known;
  logic [3:0]       sc_flags;
`ifdef ALU_MDU_EN
  logic             sc_multi;
`endif

  // Single-cycle datapath; FlagsOut is {Z, C, N, O}.
  always_comb begin
    b_in   = (FunSel == 5'h06) ? ~B : B;
    cin    = (FunSel == 5'h06) | ((FunSel == 5'h05) & FlagsOut[2]);
    sum    = {1'b0, A} + {1'b0, b_in} + {{WIDTH{1'b0}}, cin};
    sc_res = A;
    c_v    = FlagsOut[2];
    o_v    = FlagsOut[0];
    known  = 1'b1;
`ifdef ALU_MDU_EN
    sc_multi = 1'b0;
`endif
    case (FunSel)
      5'h00: sc_res = A;
      5'h01: sc_res = B;
      5'h02: sc_res = ~A;
      5'h03: sc_res = ~B;
      5'h04, 5'h05: begin
        sc_res = sum[WIDTH-1:0];
        c_v    = sum[WIDTH];
        o_v    = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
      end
      5'h06: begin
        sc_res = sum[WIDTH-1:0];
        c_v    = sum[WIDTH];
        o_v    = (A[MSB] != B[MSB]) && (sum[MSB] == B[MSB]);
      end
      5'h07: sc_res = A & B;
      5'h08: sc_res = A | B;
      5'h09: sc_res = A ^ B;
      5'h0A: sc_res = ~(A & B);
      5'h0B: begin sc_res = {A[WIDTH-2:0], 1'b0};        c_v = A[MSB]; end
      5'h0C: begin sc_res = {1'b0, A[WIDTH-1:1]};        c_v = A[0];   end
      5'h0D: begin sc_res = {A[MSB], A[WIDTH-1:1]};      c_v = A[0];   end
      5'h0E: begin sc_res = {A[WIDTH-2:0], FlagsOut[2]}; c_v = A[MSB]; end
      5'h0F: begin sc_res = {FlagsOut[2], A[WIDTH-1:1]}; c_v = A[0];   end
`ifdef ALU_MDU_EN
      5'h10, 5'h11: sc_multi = 1'b1;
      // Divide-by-zero finishes here: DIV gives all-ones, REM gives A.
      5'h12: if (B == '0) begin sc_res = '1; o_v = 1'b1; end else sc_multi = 1'b1;
      5'h13: if (B == '0) o_v = 1'b1; else sc_multi = 1'b1;
`endif
      default: known = 1'b0;
    endcase
    sc_flags = (WF && known) ? {sc_res == '0, c_v, sc_res[MSB], o_v} : FlagsOut;
  end

`ifdef ALU_MDU_EN
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [1:0]       op;
  logic             wf_q;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH:0]   sum_m;
  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] mdu_res;
  logic [3:0]       mdu_flags;

  // MUL: {hi,lo} shift-add with multiplier in lo. DIV: restoring, remainder in hi, quotient in lo.
  // diff[WIDTH] is the borrow, so it is clear exactly when the shifted remainder >= divisor.
  always_comb begin
    sum_m = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    sh    = {hi, lo[MSB]};
    diff  = sh - {1'b0, mcand};
    if (op[1]) begin
      if (!diff[WIDTH]) begin
        step_hi = diff[WIDTH-1:0];
        step_lo = {lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = sh[WIDTH-1:0];
        step_lo = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      {step_hi, step_lo} = {sum_m, lo[WIDTH-1:1]};
    end
    mdu_res   = op[0] ? step_hi : step_lo;
    mdu_flags = {mdu_res == '0, op[1] ? FlagsOut[2] : (step_hi != '0),
                 mdu_res[MSB], op[1] ? 1'b0 : FlagsOut[0]};
  end

  // The last RUN step registers the result on its way into FIN, so FIN is the Done cycle
  // and behaves like IDLE for a back-to-back Start.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op       <= '0;
      wf_q     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      mcand    <= '0;
      ALUOut   <= '0;
      FlagsOut <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE, FIN: begin
          state <= IDLE;
          if (Start) begin
            if (sc_multi) begin
              op    <= FunSel[1:0];
              wf_q  <= WF;
              hi    <= '0;
              lo    <= FunSel[1] ? A : B;
              mcand <= FunSel[1] ? B : A;
              cnt   <= CW'(WIDTH);
              Busy  <= 1'b1;
              state <= RUN;
            end else begin
              ALUOut   <= sc_res;
              FlagsOut <= sc_flags;
              Done     <= 1'b1;
            end
          end
        end
        RUN: begin
          hi  <= step_hi;
          lo  <= step_lo;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            ALUOut <= mdu_res;
            if (wf_q) FlagsOut <= mdu_flags;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= FIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign Busy = 1'b0;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      ALUOut   <= '0;
      FlagsOut <= '0;
      Done     <= 1'b0;
    end else begin
      Done <= Start;
      if (Start) begin
        ALUOut   <= sc_res;
        FlagsOut <= sc_flags;
      end
    end
  end
`endif

endmodule
